pipeline_hazard_ctrl: RTL and testbench

//   Hazard controller for the 5-stage pipeline (IF/ID/EX/DM/WB).

---
 rtl/pipeline_hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage IF/ID/EX/DM/WB pipeline: load-use stall, branch
// flush, EX operand forwarding selects and a syscall drain-then-halt sequence.
module pipeline_hazard_ctrl #(
  parameter int unsigned CntWidth    = 16,
  parameter int unsigned DrainCycles = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [4:0]          id_req_a,
  input  logic                id_use_a,
  input  logic [4:0]          id_req_b,
  input  logic                id_use_b,
  input  logic                id_w_en,
  input  logic [4:0]          id_req_w,
  input  logic                id_is_load,
  input  logic                ex_load_pc,
  input  logic                ex_halt,
  output logic                pc_en,
  output logic                if_id_en,
  output logic                if_id_flush,
  output logic                id_ex_flush,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                halted,
  output logic [CntWidth-1:0] stall_cnt,
  output logic [1:0]          dbg_state
);

  // Handshake-free block: every output is a per-cycle level; en=0 freezes all state
  // and deasserts every enable and flush.
  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam int unsigned DrainW = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainCycles - 1);

  state_e              state_q, state_d;
  logic [DrainW-1:0]   drain_q, drain_d;
  logic                ex_v_q, ex_v_d;
  logic [4:0]          ex_reg_q, ex_reg_d;
  logic                ex_load_q, ex_load_d;
  logic                dm_v_q, dm_v_d;
  logic [4:0]          dm_reg_q, dm_reg_d;
  logic [1:0]          fwd_a_q, fwd_a_d;
  logic [1:0]          fwd_b_q, fwd_b_d;
  logic [CntWidth-1:0] stall_cnt_q, stall_cnt_d;
  logic                load_use;
  logic                stall;

  // Slots never hold register 0 as valid, so a zero source can never match.
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic [4:0] src,
                                         input logic exv, input logic [4:0] exr,
                                         input logic dmv, input logic [4:0] dmr);
    logic [1:0] sel;
    sel = 2'd0;
    if (use_src) begin
      if (exv && src == exr) begin
        sel = 2'd1;
      end else if (dmv && src == dmr) begin
        sel = 2'd2;
      end
    end
    return sel;
  endfunction

  assign load_use = ex_v_q && ex_load_q &&
                    ((id_use_a && id_req_a == ex_reg_q) || (id_use_b && id_req_b == ex_reg_q));
  // A taken branch squashes the consumer anyway, so it must not also stall.
  assign stall    = (state_q == ST_RUN) && load_use && !ex_load_pc;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    ex_v_d      = ex_v_q;
    ex_reg_d    = ex_reg_q;
    ex_load_d   = ex_load_q;
    dm_v_d      = dm_v_q;
    dm_reg_d    = dm_reg_q;
    fwd_a_d     = fwd_a_q;
    fwd_b_d     = fwd_b_q;
    stall_cnt_d = stall_cnt_q;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (en) begin
      case (state_q)
        ST_RUN: begin
          pc_en       = !stall;
          if_id_en    = !stall;
          if_id_flush = ex_load_pc;
          id_ex_flush = stall || ex_load_pc;
          if (ex_halt) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end
        end
        ST_DRAIN: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (drain_q == DrainLast) begin
            state_d = ST_HALTED;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
        ST_HALTED: begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase

      dm_v_d    = ex_v_q;
      dm_reg_d  = ex_reg_q;
      ex_v_d    = !id_ex_flush && id_w_en && (id_req_w != 5'd0);
      ex_reg_d  = id_req_w;
      ex_load_d = id_is_load;
      if (id_ex_flush) begin
        fwd_a_d = 2'd0;
        fwd_b_d = 2'd0;
      end else begin
        fwd_a_d = fwd_sel(id_use_a, id_req_a, ex_v_q, ex_reg_q, dm_v_q, dm_reg_q);
        fwd_b_d = fwd_sel(id_use_b, id_req_b, ex_v_q, ex_reg_q, dm_v_q, dm_reg_q);
      end
      if (stall && stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      ex_v_q      <= 1'b0;
      ex_reg_q    <= 5'd0;
      ex_load_q   <= 1'b0;
      dm_v_q      <= 1'b0;
      dm_reg_q    <= 5'd0;
      fwd_a_q     <= 2'd0;
      fwd_b_q     <= 2'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      ex_v_q      <= ex_v_d;
      ex_reg_q    <= ex_reg_d;
      ex_load_q   <= ex_load_d;
      dm_v_q      <= dm_v_d;
      dm_reg_q    <= dm_reg_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_a     = fwd_a_q;
  assign fwd_b     = fwd_b_q;
  assign halted    = (state_q == ST_HALTED);
  assign stall_cnt = stall_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed pipeline scenarios plus random stimulus,
// checked every cycle against an in-flight-instruction model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int CW = 16;
  localparam int DC = 2;

  logic clk = 1'b0;
  logic rst, en;
  logic [4:0] id_req_a, id_req_b, id_req_w;
  logic id_use_a, id_use_b, id_w_en, id_is_load, ex_load_pc, ex_halt;

  logic pc_en, if_id_en, if_id_flush, id_ex_flush, halted;
  logic [1:0] fwd_a, fwd_b, dbg_state;
  logic [CW-1:0] stall_cnt;

  logic s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_flush, s_halted;
  logic [1:0] s_fwd_a, s_fwd_b, s_dbg_state;
  logic [1:0] s_stall_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CntWidth(CW), .DrainCycles(DC)) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .id_req_a(id_req_a), .id_use_a(id_use_a), .id_req_b(id_req_b), .id_use_b(id_use_b),
    .id_w_en(id_w_en), .id_req_w(id_req_w), .id_is_load(id_is_load),
    .ex_load_pc(ex_load_pc), .ex_halt(ex_halt),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  pipeline_hazard_ctrl #(.CntWidth(2), .DrainCycles(DC)) u_sat (
    .clk(clk), .rst(rst), .en(en),
    .id_req_a(id_req_a), .id_use_a(id_use_a), .id_req_b(id_req_b), .id_use_b(id_use_b),
    .id_w_en(id_w_en), .id_req_w(id_req_w), .id_is_load(id_is_load),
    .ex_load_pc(ex_load_pc), .ex_halt(ex_halt),
    .pc_en(s_pc_en), .if_id_en(s_if_id_en), .if_id_flush(s_if_id_flush),
    .id_ex_flush(s_id_ex_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .halted(s_halted),
    .stall_cnt(s_stall_cnt), .dbg_state(s_dbg_state)
  );

  // Model: instructions that entered EX, youngest first (index 0 = in EX, 1 = in DM).
  typedef struct {
    int dst;
    bit ld;
  } ent_t;
  ent_t fly_q[$];
  int   mode;        // 0 run, 1 drain, 2 halted
  int   drain_left;
  int   stalls;
  int   m_fa, m_fb;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_hazard();
    int d;
    if (mode != 0 || fly_q.size() == 0 || ex_load_pc) return 1'b0;
    d = fly_q[0].dst;
    if (!fly_q[0].ld || d == 0) return 1'b0;
    return (id_use_a && int'(id_req_a) == d) || (id_use_b && int'(id_req_b) == d);
  endfunction

  function automatic int m_dist(input bit use_s, input int src);
    if (!use_s || src == 0) return 0;
    for (int i = 0; i < fly_q.size() && i < 2; i++) begin
      if (fly_q[i].dst == src) return i + 1;
    end
    return 0;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic drive(input bit ua, input int a, input bit ub, input int b, input bit w,
                       input int rw, input bit ld, input bit lpc, input bit hlt);
    rst = 1'b0; en = 1'b1;
    id_use_a = ua; id_req_a = 5'(a); id_use_b = ub; id_req_b = 5'(b);
    id_w_en = w; id_req_w = 5'(rw); id_is_load = ld; ex_load_pc = lpc; ex_halt = hlt;
  endtask

  // Inputs are already applied; check outputs, clock once, advance the model.
  task automatic cycle();
    bit hz;
    bit bubble;
    logic [3:0] e;
    ent_t ne;
    #1;
    hz = m_hazard();
    if (!en)            e = 4'b0000;
    else if (mode == 0) e = {!hz, !hz, ex_load_pc, hz || ex_load_pc};
    else                e = 4'b0011;
    check("ctl", 32'({pc_en, if_id_en, if_id_flush, id_ex_flush}), 32'(e));
    check("ctl_sat", 32'({s_pc_en, s_if_id_en, s_if_id_flush, s_id_ex_flush}), 32'(e));
    @(posedge clk);
    bubble = e[0];
    if (rst) begin
      mode = 0; fly_q.delete(); stalls = 0; m_fa = 0; m_fb = 0;
    end else if (en) begin
      if (hz) stalls++;
      m_fa = bubble ? 0 : m_dist(id_use_a, int'(id_req_a));
      m_fb = bubble ? 0 : m_dist(id_use_b, int'(id_req_b));
      ne.dst = (!bubble && id_w_en) ? int'(id_req_w) : 0;
      ne.ld  = id_is_load;
      fly_q.push_front(ne);
      if (fly_q.size() > 2) void'(fly_q.pop_back());
      if (mode == 0 && ex_halt) begin
        mode = 1; drain_left = DC;
      end else if (mode == 1) begin
        drain_left--;
        if (drain_left == 0) mode = 2;
      end
    end
    #1;
    check("fwd_a", 32'(fwd_a), 32'(m_fa));
    check("fwd_b", 32'(fwd_b), 32'(m_fb));
    check("halted", 32'(halted), 32'(mode == 2));
    check("stall_cnt", 32'(stall_cnt), 32'(min_i(stalls, 65535)));
    check("stall_cnt_sat", 32'(s_stall_cnt), 32'(min_i(stalls, 3)));
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    mode = 0; fly_q.delete(); stalls = 0; m_fa = 0; m_fb = 0; drain_left = 0;
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("rst_pc_en", 32'(pc_en), 32'd1);
    check("rst_if_id_en", 32'(if_id_en), 32'd1);
    check("rst_flushes", 32'({if_id_flush, id_ex_flush}), 32'd0);
    check("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);

    // lw $8 ; add $9,$8,$8 (stalls once, then forwards from DM/WB)
    @(negedge clk); drive(0, 0, 0, 0, 1, 8, 1, 0, 0); cycle();
    @(negedge clk); drive(1, 8, 1, 8, 1, 9, 0, 0, 0); cycle();
    check("lu_cnt", 32'(stall_cnt), 32'd1);
    @(negedge clk); drive(1, 8, 1, 8, 1, 9, 0, 0, 0); cycle();
    check("lu_fwd", 32'({fwd_a, fwd_b}), 32'b1010);

    // add $8 ; sub $10,$8,$3
    @(negedge clk); drive(0, 0, 0, 0, 1, 8, 0, 0, 0); cycle();
    @(negedge clk); drive(1, 8, 1, 3, 1, 10, 0, 0, 0); cycle();
    check("ex_fwd", 32'({fwd_a, fwd_b}), 32'b0100);

    // add $8 ; nop ; or $11,$8,$0
    @(negedge clk); drive(0, 0, 0, 0, 1, 8, 0, 0, 0); cycle();
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    @(negedge clk); drive(1, 8, 1, 0, 1, 11, 0, 0, 0); cycle();
    check("dm_fwd", 32'({fwd_a, fwd_b}), 32'b1000);

    // lw $0 ; use $0 (never a hazard)
    @(negedge clk); drive(0, 0, 0, 0, 1, 0, 1, 0, 0); cycle();
    @(negedge clk); drive(1, 0, 1, 0, 1, 12, 0, 0, 0); cycle();
    check("r0_cnt", 32'(stall_cnt), 32'd1);

    // load-use pending while a branch resolves in EX
    @(negedge clk); drive(0, 0, 0, 0, 1, 5, 1, 0, 0); cycle();
    @(negedge clk); drive(1, 5, 0, 0, 1, 6, 0, 1, 0); cycle();
    check("br_cnt", 32'(stall_cnt), 32'd1);
    check("br_fwd", 32'({fwd_a, fwd_b}), 32'd0);

    // halt: drain with an en=0 gap, then stay halted
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); en = 1'b0; cycle();
    check("drain_hold", 32'(halted), 32'd0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();
    check("halt_done", 32'(halted), 32'd1);
    @(negedge clk); drive(1, 1, 1, 2, 1, 3, 1, 1, 0); cycle();
    check("halt_held", 32'(halted), 32'd1);

    // reset in the middle of a drain
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); rst = 1'b1; cycle();
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 1); cycle();
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0, 0); rst = 1'b1; cycle();
    check("rst_drain_halted", 32'(halted), 32'd0);
    check("rst_drain_cnt", 32'(stall_cnt), 32'd0);

    // five back-to-back load-use stalls saturate the 2-bit counter at 3
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive(0, 0, 0, 0, 1, 7, 1, 0, 0); cycle();
      @(negedge clk); drive(1, 7, 0, 0, 0, 0, 0, 0, 0); cycle();
      @(negedge clk); drive(1, 7, 0, 0, 0, 0, 0, 0, 0); cycle();
    end
    check("sat_small", 32'(s_stall_cnt), 32'd3);
    check("sat_wide", 32'(stall_cnt), 32'd5);

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 39) == 0));
      en  = 1'($urandom_range(0, 7) != 0);
      rst = 1'($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
